stack_64x36: RTL and testbench

- LIFO data stack: 64 entries deep, 36 bits wide, for the CPU core's operand/return stacks.
- Top two entries (top, next) are always visible as registered outputs, so the ALU can read both operands with zero latency.
- Push and drop are single-cycle commands sampled on the rising clock edge.
- Depth and full/empty/error status go to the control unit.

---
 rtl/stack_64x36_if.sv | 38 +++
 rtl/stack_64x36.sv | 113 +++++++++++
 tb/tb_stack_64x36.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/stack_64x36_if.sv
// stack_64x36_if
//   Command/status bundle between a stack user and stack_64x36.
//   Signals:
//     push, drop  commands sampled on the rising clock edge
//     D           data to push
//     top, next   registered depth-1 / depth-2 entries (0 when absent)
//     depth       current entry count, 0..DEPTH
//     empty, full status decoded from depth
//     overflow    one-cycle pulse: push rejected because full
//     underflow   one-cycle pulse: drop rejected because empty
//   Modports: master (stack user), slave (the stack itself).
interface stack_64x36_if #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 36
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic             push;
  logic             drop;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, drop, D,
    input  top, next, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  push, drop, D,
    output top, next, depth, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_64x36.sv
// stack_64x36
//   LIFO operand/return stack, DEPTH entries of WIDTH bits. The two most
//   recent entries live in registers (top, next) so both ALU operands are
//   available with zero latency; deeper entries sit in a DEPTH-2 word array
//   addressed by stack position counted from the bottom.
//   Ports:
//     clk  system clock, all state changes on the rising edge
//     rst  synchronous active-high reset (overrides push/drop)
//     bus  stack_64x36_if.slave: push/drop/D in; top/next/depth/empty/full/
//          overflow/underflow out
module stack_64x36 #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 36
) (
  input  logic           clk,
  input  logic           rst,
  stack_64x36_if.slave   bus
);

  localparam int unsigned DW        = $clog2(DEPTH) + 1;
  localparam int unsigned MEM_WORDS = (DEPTH > 2) ? DEPTH - 2 : 1;
  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic        HAS_MEM   = (DEPTH > 2);

  // Registered state
  logic [WIDTH-1:0] top_q;
  logic [WIDTH-1:0] next_q;
  logic [DW-1:0]    depth_q;
  logic             overflow_q;
  logic             underflow_q;

  // Spill array: with n entries, top is entry n, next is entry n-1 and
  // entries 1..n-2 are held in mem[0..n-3].
  logic [WIDTH-1:0] mem [MEM_WORDS];

  // Command decode
  logic             is_empty;
  logic             is_full;
  logic             do_push;
  logic             do_replace;
  logic             do_drop;
  logic             reject_push;
  logic             reject_drop;
  logic             spill;
  logic             fill;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] fill_word;

  always_comb begin
    is_empty    = (depth_q == '0);
    is_full     = (depth_q == DW'(DEPTH));

    // push+drop on an empty stack degenerates to a plain push; on a
    // non-empty stack it overwrites top only and can never be rejected.
    do_replace  = bus.push & bus.drop & ~is_empty;
    do_push     = bus.push & (~bus.drop | is_empty) & ~is_full;
    do_drop     = bus.drop & ~bus.push & ~is_empty;
    reject_push = bus.push & ~bus.drop & is_full;
    reject_drop = bus.drop & ~bus.push & is_empty;

    // Push with n>=2: old next (entry n-1) moves to mem[n-2].
    // Drop with n>=3: entry n-2, held at mem[n-3], becomes the new next.
    spill       = HAS_MEM & do_push & (depth_q >= DW'(2));
    fill        = HAS_MEM & do_drop & (depth_q >= DW'(3));
    wr_idx      = AW'(depth_q - DW'(2));
    rd_idx      = AW'(depth_q - DW'(3));
    fill_word   = fill ? mem[rd_idx] : '0;
  end

  // Array contents need no reset; unread slots are never exposed.
  always_ff @(posedge clk) begin
    if (!rst && spill) begin
      mem[wr_idx] <= next_q;
    end
  end

  // Invariant relied on below: next_q is 0 whenever depth<2 and top_q is 0
  // whenever depth==0, so a drop that shifts next into top (and 0 or the
  // array word into next) leaves vacated positions reading 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q       <= '0;
      next_q      <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= reject_push;
      underflow_q <= reject_drop;
      if (do_push) begin
        top_q   <= bus.D;
        next_q  <= top_q;
        depth_q <= depth_q + DW'(1);
      end else if (do_replace) begin
        top_q   <= bus.D;
      end else if (do_drop) begin
        top_q   <= next_q;
        next_q  <= fill_word;
        depth_q <= depth_q - DW'(1);
      end
    end
  end

  assign bus.top       = top_q;
  assign bus.next      = next_q;
  assign bus.depth     = depth_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_stack_64x36.sv
module tb_stack_64x36;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WIDTH = 36;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stack_64x36_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) sif ();

  stack_64x36 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Reference model: plain queue, last element is the top of stack.
  logic [WIDTH-1:0] model_q[$];
  logic             exp_ovf;
  logic             exp_unf;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    logic [WIDTH-1:0] et;
    logic [WIDTH-1:0] en;
    n  = model_q.size();
    et = (n >= 1) ? model_q[n-1] : '0;
    en = (n >= 2) ? model_q[n-2] : '0;
    check({tag, ".top"},       64'(sif.top),       64'(et));
    check({tag, ".next"},      64'(sif.next),      64'(en));
    check({tag, ".depth"},     64'(sif.depth),     64'(n));
    check({tag, ".empty"},     64'(sif.empty),     64'(n == 0));
    check({tag, ".full"},      64'(sif.full),      64'(n == DEPTH));
    check({tag, ".overflow"},  64'(sif.overflow),  64'(exp_ovf));
    check({tag, ".underflow"}, 64'(sif.underflow), 64'(exp_unf));
  endtask

  task automatic model_update(input logic r, input logic p, input logic dr, input logic [WIDTH-1:0] d);
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (r) begin
      model_q.delete();
    end else if (p && dr) begin
      if (model_q.size() == 0) model_q.push_back(d);
      else model_q[model_q.size()-1] = d;
    end else if (p) begin
      if (model_q.size() == DEPTH) exp_ovf = 1'b1;
      else model_q.push_back(d);
    end else if (dr) begin
      if (model_q.size() == 0) exp_unf = 1'b1;
      else void'(model_q.pop_back());
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input string tag, input logic r, input logic p, input logic dr,
                      input logic [WIDTH-1:0] d);
    rst      = r;
    sif.push = p;
    sif.drop = dr;
    sif.D    = d;
    @(posedge clk);
    #1;
    model_update(r, p, dr, d);
    check_all(tag);
  endtask

  initial begin
    rst      = 1'b1;
    sif.push = 1'b0;
    sif.drop = 1'b0;
    sif.D    = '0;

    // Reset then idle
    step("reset", 1'b1, 1'b0, 1'b0, '0);
    step("idle",  1'b0, 1'b0, 1'b0, '0);

    // Three pushes, then drain with one extra drop
    step("push16",  1'b0, 1'b1, 1'b0, 36'd16);
    step("push137", 1'b0, 1'b1, 1'b0, 36'd137);
    step("push3",   1'b0, 1'b1, 1'b0, 36'd3);
    step("drop1",   1'b0, 1'b0, 1'b1, '0);
    step("drop2",   1'b0, 1'b0, 1'b1, '0);
    step("drop3",   1'b0, 1'b0, 1'b1, '0);
    step("drop_uf", 1'b0, 1'b0, 1'b1, '0);
    step("idle_uf", 1'b0, 1'b0, 1'b0, '0);

    // Fill to full, overflow, drain completely
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b0, 1'b1, 1'b0, 36'(i));
    step("push_of", 1'b0, 1'b1, 1'b0, 36'd99);
    step("idle_of", 1'b0, 1'b0, 1'b0, '0);
    step("repl_full", 1'b0, 1'b1, 1'b1, 36'hF_FFFF_FFFF);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b0, 1'b1, '0);
    step("drain_uf", 1'b0, 1'b0, 1'b1, '0);

    // Replace top at depth 2, then push+drop on empty
    step("push7",   1'b0, 1'b1, 1'b0, 36'd7);
    step("push5",   1'b0, 1'b1, 1'b0, 36'd5);
    step("repl42",  1'b0, 1'b1, 1'b1, 36'd42);
    step("drop_a",  1'b0, 1'b0, 1'b1, '0);
    step("drop_b",  1'b0, 1'b0, 1'b1, '0);
    step("repl_e9", 1'b0, 1'b1, 1'b1, 36'd9);

    // Reset while pushing at depth 10
    step("drop_c", 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 10; i++) step("pre_rst", 1'b0, 1'b1, 1'b0, 36'(100 + i));
    step("rst_push", 1'b1, 1'b1, 1'b0, 36'd555);
    step("post_rst", 1'b0, 1'b0, 1'b0, '0);

    // Randomized traffic with phases biased toward growing and shrinking
    for (int i = 0; i < 800; i++) begin
      int unsigned r;
      logic p;
      logic dr;
      logic [WIDTH-1:0] d;
      r  = $urandom_range(0, 99);
      d  = {4'($urandom), $urandom};
      if (((i / 100) % 2) == 0) begin
        p  = (r < 70);
        dr = (r >= 60 && r < 80);
      end else begin
        p  = (r < 20);
        dr = (r >= 10 && r < 80);
      end
      step("rand", (r == 99) ? 1'b1 : 1'b0, p, dr, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
